// File: rtl/mem_responder.sv
// mem_responder: wait-stated word RAM serving held core load/store requests with byte-lane steering
module mem_responder #(
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          MEM_WORDS   = 4096,
  parameter int          WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [2:0]            mem_f3,
  output logic [31:0]           mem_rdata,
  output logic                  mem_complete,
  output logic                  mem_error
);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] LO = (ADDR_WIDTH+1)'(MEM_BASE);
  localparam logic [ADDR_WIDTH:0] HI = LO + (ADDR_WIDTH+1)'(4 * MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  match, err, fire;
  logic [IW-1:0]         idx;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [31:0]           wsteer;
  logic [31:0]           mem [MEM_WORDS];
  // the live request is still the one captured; a dropped request never matches
  assign match = (mem_read | mem_write) && mem_read == rd_q && mem_write == wr_q &&
                 mem_addr == addr_q && mem_wdata == wdata_q && mem_f3 == f3_q;
  // decode the captured request: legality, word index, lane enables and response outputs
  always_comb begin
    idx          = IW'((addr_q - ADDR_WIDTH'(MEM_BASE)) >> 2);
    lane         = addr_q[1:0];
    err          = (rd_q & wr_q) | (f3_q[1:0] == 2'b11) | (f3_q[1:0] == 2'b01 && lane[0]) |
                   (f3_q[1:0] == 2'b10 && lane != 2'b00) | ({1'b0, addr_q} < LO) | ({1'b0, addr_q} >= HI);
    be           = f3_q[1:0] == 2'b00 ? 4'b0001 << lane : f3_q[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
    wsteer       = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    fire         = state_q == RESP && match;
    mem_complete = fire;
    mem_error    = fire & err;
    mem_rdata    = fire && !err ? mem[idx] >> {lane, 3'b000} : 32'h0;
  end
  // next state: capture in IDLE, count down in WAIT, abort on any request change, respond once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    if (state_q == IDLE) begin
      if (mem_read | mem_write) begin
        rd_d    = mem_read;
        wr_d    = mem_write;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        f3_d    = mem_f3;
        cnt_d   = 4'(WAIT_STATES);
        state_d = WAIT_STATES > 0 ? WAIT : RESP;
      end
    end else if (!match || state_q == RESP) begin
      state_d = IDLE;
    end else begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end
  end
  // state and captured request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      f3_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
    end
  end
  // store commits on the completing edge, only to enabled lanes of a legal write
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (fire && wr_q && !err && be[i]) mem[idx][8*i +: 8] <= wsteer[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder at one and three wait states
module tb_mem_responder;
  logic        clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] r1, r3, rdo;
  logic        c1, c3, e1, e3, cmp, ero;
  typedef struct packed { logic [31:0] d; logic e; logic chk; } exp_t;
  exp_t sbq[$];
  int   checks = 0, fails = 0;
  time  t_done = 0;
  assign cmp = sel ? c3 : c1;
  assign ero = sel ? e3 : e1;
  assign rdo = sel ? r3 : r1;
  always #5 clk = ~clk;
  mem_responder #(.ADDR_WIDTH(32), .MEM_BASE(32'h0), .MEM_WORDS(256), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd & ~sel), .mem_write(wr & ~sel), .mem_addr(addr),
    .mem_wdata(wdata), .mem_f3(f3), .mem_rdata(r1), .mem_complete(c1), .mem_error(e1));
  mem_responder #(.ADDR_WIDTH(32), .MEM_BASE(32'h0), .MEM_WORDS(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd & sel), .mem_write(wr & sel), .mem_addr(addr),
    .mem_wdata(wdata), .mem_f3(f3), .mem_rdata(r3), .mem_complete(c3), .mem_error(e3));

  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input logic [31:0] xd, input logic xe, input string nm);
    int   n;
    exp_t x;
    rd = r; wr = w; addr = a; wdata = d; f3 = f;
    sbq.push_back({xd, xe, r | xe});
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmp && n < 20);
    x = sbq.pop_front();
    checks++;
    if (!cmp) begin
      fails++;
      $display("FAIL %s timeout: mem_complete=0 after %0d cycles, required 1", nm, n);
    end else begin
      t_done = $time;
      if (x.chk) begin
        checks++;
        if (rdo !== x.d) begin fails++; $display("FAIL %s rdata: got %h required %h", nm, rdo, x.d); end
      end
      checks++;
      if (ero !== x.e) begin fails++; $display("FAIL %s error: got %b required %b", nm, ero, x.e); end
      checks++;
      if (n !== (sel ? 4 : 2)) begin fails++; $display("FAIL %s latency: got %0d required %0d", nm, n, sel ? 4 : 2); end
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({c1, c3, e1, e3} !== 4'b0 || r1 !== 32'h0 || r3 !== 32'h0) begin
      fails++; $display("FAIL reset outputs: got c=%b%b e=%b%b r=%h/%h required all 0", c1, c3, e1, e3, r1, r3);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_rw;
    sel = 1'b0;
    txn(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, "wr_word_10");
    txn(1, 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, "rd_word_10");
  endtask

  task automatic test_byte_lanes;
    sel = 1'b0;
    txn(0, 1, 32'h13, 32'h123456AA, 3'b000, 32'h0, 0, "wr_byte_13");
    txn(1, 0, 32'h10, 32'h0, 3'b010, 32'hAAADBEEF, 0, "rd_word_after_byte");
    txn(1, 0, 32'h12, 32'h0, 3'b001, 32'h0000AAAD, 0, "rd_half_12");
    txn(1, 0, 32'h13, 32'h0, 3'b100, 32'h000000AA, 0, "rd_byte_f3bit2");
    txn(0, 1, 32'h12, 32'hFFFF7711, 3'b001, 32'h0, 0, "wr_half_12");
    txn(1, 0, 32'h10, 32'h0, 3'b010, 32'h7711BEEF, 0, "rd_word_after_half");
  endtask

  task automatic test_errors;
    sel = 1'b0;
    txn(1, 0, 32'h12, 32'h0, 3'b010, 32'h0, 1, "err_misaligned_word");
    txn(1, 0, 32'h400, 32'h0, 3'b000, 32'h0, 1, "err_above_range");
    txn(0, 1, 32'h11, 32'h0000FFFF, 3'b001, 32'h0, 1, "err_misaligned_half_wr");
    txn(1, 1, 32'h10, 32'h0, 3'b010, 32'h0, 1, "err_read_and_write");
    txn(0, 1, 32'h10, 32'h0, 3'b011, 32'h0, 1, "err_size_11");
    txn(1, 0, 32'h10, 32'h0, 3'b010, 32'h7711BEEF, 0, "rd_word_unchanged");
    txn(0, 1, 32'h3FC, 32'h5A000000, 3'b010, 32'h0, 0, "wr_last_word");
    txn(1, 0, 32'h3FF, 32'h0, 3'b000, 32'h0000005A, 0, "rd_last_byte");
  endtask

  task automatic test_abort;
    int   n;
    logic seen;
    sel = 1'b1;
    txn(0, 1, 32'h20, 32'h11111111, 3'b010, 32'h0, 0, "ws3_wr_20");
    rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h55555555; f3 = 3'b010;
    @(posedge clk);
    @(posedge clk); #1;
    addr = 32'h24;
    @(negedge clk); seen = cmp;
    @(posedge clk);
    @(negedge clk); seen = seen | cmp;
    checks++;
    if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_complete: got %b required 0", seen); end
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmp && n < 20);
    checks++;
    if (!cmp || n != 4) begin fails++; $display("FAIL abort_reaccept: complete=%b after %0d cycles, required 1 after 4", cmp, n); end
    checks++;
    if (ero !== 1'b0) begin fails++; $display("FAIL abort_reaccept_err: got %b required 0", ero); end
    @(posedge clk); #1;
    wr = 1'b0;
    txn(1, 0, 32'h20, 32'h0, 3'b010, 32'h11111111, 0, "ws3_rd_20_unwritten");
    txn(1, 0, 32'h24, 32'h0, 3'b010, 32'h55555555, 0, "ws3_rd_24");
  endtask

  task automatic test_back_to_back;
    time t_prev;
    sel = 1'b0;
    for (int i = 0; i < 8; i++)
      txn(0, 1, 32'h40 + 4 * i, 32'hC0DE0000 + 32'(i * 32'h01010101), 3'b010, 32'h0, 0, "b2b_wr");
    for (int i = 0; i < 8; i++) begin
      t_prev = t_done;
      txn(1, 0, 32'h40 + 4 * i, 32'h0, 3'b010, 32'hC0DE0000 + 32'(i * 32'h01010101), 0, "b2b_rd");
      if (i > 0) begin
        checks++;
        if (t_done - t_prev != 30) begin
          fails++; $display("FAIL b2b_spacing: got %0t required 30", t_done - t_prev);
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d required 0", sbq.size()); end
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    txn(0, 1, 32'h30, 32'hCAFEF00D, 3'b010, 32'h0, 0, "wr_30");
    rd = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'h12345678; f3 = 3'b010;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checks++;
    if ({c1, e1} !== 2'b0 || r1 !== 32'h0) begin
      fails++; $display("FAIL rst_in_wait: got c=%b e=%b r=%h required 0", c1, e1, r1);
    end
    wr = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    txn(1, 0, 32'h30, 32'h0, 3'b010, 32'hCAFEF00D, 0, "rd_30_after_rst");
    rd = 1'b1; addr = 32'h30; f3 = 3'b010;
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (c1 !== 1'b1 || r1 !== 32'hCAFEF00D) begin
      fails++; $display("FAIL resp_before_rst: got c=%b r=%h required 1 cafef00d", c1, r1);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({c1, e1} !== 2'b0 || r1 !== 32'h0) begin
      fails++; $display("FAIL rst_in_resp: got c=%b e=%b r=%h required 0", c1, e1, r1);
    end
    rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    txn(1, 0, 32'h32, 32'h0, 3'b001, 32'h0000CAFE, 0, "rd_half_after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_word_rw;
    test_byte_lanes;
    test_errors;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's multi-cycle memory interface.
- Accepts a held read/write request (address, data, funct3 size) and serves it from an internal word-organised RAM after a configurable number of wait states.
- Signals completion with a one-cycle `mem_complete` pulse; the core holds its request until it sees this pulse.
- Handles byte-lane steering on both writes and reads, flags errors, and aborts a transaction cleanly when the core withdraws or changes its request (for example on an exception redirect).

Parameters:
- ADDR_WIDTH, 32: width of `mem_addr`.
- MEM_BASE, 32'h0000_0000: byte address of RAM word 0; must be 4-byte aligned.
- MEM_WORDS, 4096: RAM depth in 32-bit words.
- WAIT_STATES, 1: extra cycles between acceptance and completion; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request, level, held by the core until completion.
- mem_write  in  1  write request, level, held by the core until completion.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  32  store data, right-justified.
- mem_f3  in  3  funct3 of the access; bits [1:0] give the size: 00 byte, 01 half, 10 word. Bit 2 is ignored.
- mem_rdata  out  32  load data, right-justified; valid only while `mem_complete`=1.
- mem_complete  out  1  one-cycle completion pulse.
- mem_error  out  1  valid with `mem_complete`; 1 means the access was not performed.

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, `mem_complete`=0, `mem_error`=0, `mem_rdata`=0. RAM contents are not reset. Reset asserted mid-transaction drops the transaction with no RAM write.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `mem_read` or `mem_write` is high, capture {read, write, addr, wdata, f3} and load counter=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise to RESP.
- WAIT:
  - Each cycle, compare the live request against the captured request.
  - On a mismatch, or if both request lines are low, abort: go to IDLE with no completion and no write.
  - Otherwise decrement the counter and go to RESP when it reaches 0.
- RESP:
  - Perform the same comparison; a mismatch aborts to IDLE.
  - Otherwise, in this cycle: `mem_complete`=1, `mem_rdata` and `mem_error` driven, the write committed to RAM on the same edge, then go to IDLE.
  - The request still visible during the RESP cycle belongs to the completing transaction and is not re-accepted.
- Latency: `mem_complete` goes high exactly WAIT_STATES+1 cycles after the acceptance edge. Back-to-back throughput is one transaction per WAIT_STATES+2 cycles; a new request is accepted in the cycle after the completion pulse.
- Error conditions, any of which gives `mem_complete`=1, `mem_error`=1, `mem_rdata`=0 and no write:
  - `mem_read` and `mem_write` both high;
  - size 11;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - address below MEM_BASE or at/above MEM_BASE+4*MEM_WORDS.
- Write steering:
  - Word index = (addr−MEM_BASE)>>2; lane = addr[1:0].
  - Byte: write `mem_wdata[7:0]` to byte lane `lane`.
  - Half: write `mem_wdata[15:0]` to lanes `lane` and `lane`+1.
  - Word: write all four lanes. Unselected lanes are unchanged.
- Read steering: `mem_rdata` = RAM word >> (8*lane), zero-filled above. The core performs sign extension and masking itself.
- Only the captured request is used for the access; input changes after capture are used only for the abort comparison.

Test Plan:
- WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then word read 0x10 → each `mem_complete` arrives 2 cycles after acceptance, `mem_error`=0, read returns 0xDEADBEEF.
- Byte write 0xAA to 0x13, then word read 0x10 → 0xAAADBEEF. Half read at 0x12 → 0x0000AAAD.
- Misaligned word read at 0x12, and byte read at MEM_BASE+4*MEM_WORDS → `mem_complete`=1 with `mem_error`=1, `mem_rdata`=0, no RAM change.
- WAIT_STATES=3: write to 0x20 accepted, then the address changes to 0x24 after one wait cycle → no completion and no write. The new request is accepted the following cycle and completes 4 cycles later.
- Core model issues a read immediately after each completion pulse, 8 transactions → no request is dropped or double-served. Completion pulses are spaced WAIT_STATES+2 cycles apart.
- `rst_n` pulsed low during WAIT of a write → outputs go to 0 immediately, the RAM word keeps its old value, and the first request after release completes normally.
